// File: rtl/gray_code_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : gray_code_transmitter
// Brief    : Source-side counter driving a registered gray-coded crossing bus,
//            held stable for HOLD_CYCLES after every update.
//            Optional macro GRAY_TX_PENDING_EN buffers one request made
//            while the bus is being held.
// Revision : 1.0 - initial release
// ============================================================================
module gray_code_transmitter #(
    parameter int BUS_WIDTH   = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 increment_request,
    output logic                 ready,
    output logic [BUS_WIDTH-1:0] gray_data,
    output logic [BUS_WIDTH-1:0] binary_count,
    output logic                 wrap
);

    localparam int c_HOLD_W = $clog2(HOLD_CYCLES) + 1;

    // Hold-counter values that define the two states.
    localparam logic [c_HOLD_W-1:0] c_IDLE        = '0;
    localparam logic [c_HOLD_W-1:0] c_HOLD_RELOAD = c_HOLD_W'(HOLD_CYCLES - 1);

    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [BUS_WIDTH-1:0] r_binary;
    logic [BUS_WIDTH-1:0] r_gray;
    logic                 r_wrap;

    logic                 w_ready;
    logic                 w_request;
    logic                 w_accept;
    logic [BUS_WIDTH-1:0] w_next_binary;
    logic [BUS_WIDTH-1:0] w_next_gray;

    assign w_ready       = (r_hold_cnt == c_IDLE);
    assign w_accept      = w_request & w_ready;
    assign w_next_binary = r_binary + BUS_WIDTH'(1);
    assign w_next_gray   = w_next_binary ^ (w_next_binary >> 1);

`ifdef GRAY_TX_PENDING_EN
    logic r_pending;

    assign w_request = increment_request | r_pending;

    // A request arriving during hold is kept until the bus may change again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b0;
        end else if (increment_request && !w_ready) begin
            r_pending <= 1'b1;
        end
    end
`else
    assign w_request = increment_request;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_binary   <= '0;
            r_gray     <= '0;
            r_wrap     <= 1'b0;
            r_hold_cnt <= c_IDLE;
        end else begin
            r_wrap <= 1'b0;
            if (w_accept) begin
                r_binary   <= w_next_binary;
                r_gray     <= w_next_gray;
                r_wrap     <= &r_binary;
                r_hold_cnt <= c_HOLD_RELOAD;
            end else if (!w_ready) begin
                r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
            end
        end
    end

    assign ready        = w_ready;
    assign gray_data    = r_gray;
    assign binary_count = r_binary;
    assign wrap         = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_code_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_code_transmitter
// Brief    : Self-checking bench for gray_code_transmitter (HOLD_CYCLES=3 and
//            a second instance with HOLD_CYCLES=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_code_transmitter;

    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       increment_request = 1'b0;
    logic       req1 = 1'b0;
    logic       ready, ready1;
    logic [3:0] gray_data, gray1;
    logic [3:0] binary_count, bin1;
    logic       wrap, wrap1;

    always #5 clk = ~clk;

    gray_code_transmitter #(.BUS_WIDTH(4), .HOLD_CYCLES(HOLD)) dut (
        .clk               (clk),
        .reset             (reset),
        .increment_request (increment_request),
        .ready             (ready),
        .gray_data         (gray_data),
        .binary_count      (binary_count),
        .wrap              (wrap)
    );

    gray_code_transmitter #(.BUS_WIDTH(4), .HOLD_CYCLES(1)) dut1 (
        .clk               (clk),
        .reset             (reset),
        .increment_request (req1),
        .ready             (ready1),
        .gray_data         (gray1),
        .binary_count      (bin1),
        .wrap              (wrap1)
    );

    // Reflected gray sequence indexed by count value.
    logic [3:0] code [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    int checks = 0;
    int failures = 0;

    // Reference model: counts, edge index of last accept, buffered request.
    int   edge_no = 0;
    int   m_cnt = 0, m_last = -HOLD, m_cnt1 = 0;
    logic m_wrap = 1'b0, m_wrap1 = 1'b0, m_pend = 1'b0;
    int   wrap_obs = 0, wrap1_obs = 0;
    logic [3:0] prev_gray = 4'b0000;
    bit   have_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rq, input logic rs, input logic rq1);
        logic rdy;
        increment_request = rq;
        reset             = rs;
        req1              = rq1;
        @(posedge clk);
        edge_no++;
        if (rs) begin
            m_cnt = 0; m_wrap = 1'b0; m_last = edge_no - HOLD; m_pend = 1'b0;
            m_cnt1 = 0; m_wrap1 = 1'b0;
        end else begin
            rdy = (edge_no - m_last >= HOLD);
            if (rdy && (rq || m_pend)) begin
                m_wrap = (m_cnt == 15);
                m_cnt  = (m_cnt + 1) % 16;
                m_last = edge_no;
                m_pend = 1'b0;
            end else begin
                m_wrap = 1'b0;
`ifdef GRAY_TX_PENDING_EN
                if (rq && !rdy) m_pend = 1'b1;
`endif
            end
            if (rq1) begin
                m_wrap1 = (m_cnt1 == 15);
                m_cnt1  = (m_cnt1 + 1) % 16;
            end else begin
                m_wrap1 = 1'b0;
            end
        end
        @(negedge clk);
        chk("binary_count", binary_count, m_cnt);
        chk("gray_data", gray_data, code[m_cnt]);
        chk("ready", ready, (edge_no + 1 - m_last >= HOLD));
        chk("wrap", wrap, m_wrap);
        chk("h1_binary_count", bin1, m_cnt1);
        chk("h1_gray_data", gray1, code[m_cnt1]);
        chk("h1_ready", ready1, 1'b1);
        chk("h1_wrap", wrap1, m_wrap1);
        if (have_prev && !rs && gray_data !== prev_gray)
            chk("one_bit_flip", $countones(gray_data ^ prev_gray), 1);
        prev_gray = gray_data;
        have_prev = 1'b1;
        if (wrap === 1'b1) wrap_obs++;
        if (wrap1 === 1'b1) wrap1_obs++;
    endtask

    initial begin
        int guard;
        // Reset for two cycles.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("reset_gray", gray_data, 4'b0000);
        chk("reset_ready", ready, 1'b1);

        // Continuous request: 16 updates and a single wrap.
        wrap_obs = 0;
        for (int i = 0; i < 48; i++) step(1'b1, 1'b0, 1'b0);
        chk("phase2_wrap_pulses", wrap_obs, 1);
        chk("phase2_final_gray", gray_data, 4'b0000);

        // Request at k, k+1, then two more during a later hold.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("after_k_gray", gray_data, 4'b0001);
        step(1'b1, 1'b0, 1'b0);
        chk("k1_ready", ready, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("k2_ready", ready, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
`ifdef GRAY_TX_PENDING_EN
        chk("pending_seq_gray", gray_data, 4'b0010);
`else
        chk("dropped_seq_gray", gray_data, 4'b0011);
`endif

        // Reset in the middle of a hold with count 5.
        step(1'b0, 1'b1, 1'b0);
        guard = 0;
        while (m_cnt != 5 && guard < 40) begin
            step(1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk("pre_reset_count", binary_count, 5);
        chk("pre_reset_ready", ready, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("mid_hold_reset_count", binary_count, 0);
        chk("mid_hold_reset_ready", ready, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 3) != 0));

        // HOLD_CYCLES=1 instance with request held high.
        step(1'b0, 1'b1, 1'b0);
        wrap1_obs = 0;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
        chk("h1_wrap_pulses", wrap1_obs, 2);
        chk("h1_final_count", bin1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
